// File: rtl/zube_bus_pkg.sv
// Shared types and constants for the two-register bus master.
package zube_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_e;

  localparam logic REG_SEL_1         = 1'b0;
  localparam logic REG_SEL_2         = 1'b1;
  localparam int   BUS_W             = 8;
  localparam int   MIN_STROBE_CYCLES = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bus_master_seq.sv
// Command sequencer driving chip-select, strobes and data for
// the two-register bus target; one command outstanding at a time.
module bus_master_seq
  import zube_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_reg,
  input  logic [BUS_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [BUS_W-1:0] rsp_rdata,
  output logic             reg1_cs_b,
  output logic             reg2_cs_b,
  output logic             write_strobe_b,
  output logic             read_strobe_b,
  output logic [BUS_W-1:0] data_out,
  output logic             data_oe,
  input  logic [BUS_W-1:0] data_in
);

  localparam int MAX_CYC = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("SETUP_CYCLES must be >= 1");
  end
  if (STROBE_CYCLES < MIN_STROBE_CYCLES) begin : g_bad_strobe
    $error("STROBE_CYCLES must be >= MIN_STROBE_CYCLES");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  state_e          r_state;
  state_e          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_write;
  logic            r_reg;
  logic [BUS_W-1:0] r_wdata;

  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic             r_rsp_write;
  logic [BUS_W-1:0] r_rsp_rdata;
  logic             r_cs1_b;
  logic             r_cs2_b;
  logic             r_wstb_b;
  logic             r_rstb_b;
  logic [BUS_W-1:0] r_dout;
  logic             r_oe;

  logic w_accept;
  logic w_bus_act;
  logic w_last_stb;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_next    = ST_SETUP;
          w_cnt_nxt = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_next    = ST_STROBE;
          w_cnt_nxt = LD_STROBE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_next    = ST_HOLD;
          w_cnt_nxt = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_next    = ST_RESP;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next    = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // SETUP spends its first cycle with CS still high, so the bus
  // window opens one edge after the accept edge.
  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_bus_act  = (r_state != ST_IDLE) &&
                      ((w_next == ST_SETUP) ||
                       (w_next == ST_STROBE) ||
                       (w_next == ST_HOLD));
  assign w_last_stb = (r_state == ST_STROBE) && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_reg   <= REG_SEL_1;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= cmd_write;
        r_reg   <= cmd_reg;
        r_wdata <= cmd_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_cs1_b     <= 1'b1;
      r_cs2_b     <= 1'b1;
      r_wstb_b    <= 1'b1;
      r_rstb_b    <= 1'b1;
      r_dout      <= '0;
      r_oe        <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      r_cs1_b     <= !(w_bus_act && (r_reg == REG_SEL_1));
      r_cs2_b     <= !(w_bus_act && (r_reg == REG_SEL_2));
      r_wstb_b    <= !((w_next == ST_STROBE) && r_write);
      r_rstb_b    <= !((w_next == ST_STROBE) && !r_write);
      r_oe        <= w_bus_act && r_write;
      r_dout      <= (w_bus_act && r_write) ? r_wdata : '0;
      if (w_accept) begin
        r_rsp_write <= cmd_write;
        r_rsp_rdata <= '0;
      end else if (w_last_stb && !r_write) begin
        r_rsp_rdata <= data_in;
      end
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_write      = r_rsp_write;
  assign rsp_rdata      = r_rsp_rdata;
  assign reg1_cs_b      = r_cs1_b;
  assign reg2_cs_b      = r_cs2_b;
  assign write_strobe_b = r_wstb_b;
  assign read_strobe_b  = r_rstb_b;
  assign data_out       = r_dout;
  assign data_oe        = r_oe;

endmodule

// File: tb/tb_bus_master_seq.sv
// Bench: two sequencers (default and minimum timing), each with a
// two-register target and shared-bus model, scoreboarded responses.
module tb_bus_master_seq;
  import zube_bus_pkg::*;

  typedef struct {
    logic       pre_rst;
    int         d;
    logic       w;
    logic       r;
    logic [7:0] wd;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    logic       w;
    logic [7:0] rd;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t vt[10];

  logic clk = 1'b0;
  logic rst;

  logic       cmd_valid[2];
  logic       cmd_ready[2];
  logic       cmd_write[2];
  logic       cmd_reg[2];
  logic [7:0] cmd_wdata[2];
  logic       rsp_valid[2];
  logic       rsp_ready[2];
  logic       rsp_write[2];
  logic [7:0] rsp_rdata[2];
  logic       reg1_cs_b[2];
  logic       reg2_cs_b[2];
  logic       write_strobe_b[2];
  logic       read_strobe_b[2];
  logic [7:0] data_out[2];
  logic       data_oe[2];
  logic [7:0] data_in[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int S = (g == 0) ? 2 : 1;
    localparam int T = (g == 0) ? 4 : 3;
    localparam int H = (g == 0) ? 2 : 1;

    bus_master_seq #(
      .SETUP_CYCLES (S),
      .STROBE_CYCLES(T),
      .HOLD_CYCLES  (H)
    ) u_dut (
      .clk           (clk),
      .reset         (rst),
      .cmd_valid     (cmd_valid[g]),
      .cmd_ready     (cmd_ready[g]),
      .cmd_write     (cmd_write[g]),
      .cmd_reg       (cmd_reg[g]),
      .cmd_wdata     (cmd_wdata[g]),
      .rsp_valid     (rsp_valid[g]),
      .rsp_ready     (rsp_ready[g]),
      .rsp_write     (rsp_write[g]),
      .rsp_rdata     (rsp_rdata[g]),
      .reg1_cs_b     (reg1_cs_b[g]),
      .reg2_cs_b     (reg2_cs_b[g]),
      .write_strobe_b(write_strobe_b[g]),
      .read_strobe_b (read_strobe_b[g]),
      .data_out      (data_out[g]),
      .data_oe       (data_oe[g]),
      .data_in       (data_in[g])
    );

    // Target: commits writes when the strobe rises, drives read
    // data only after two cycles of read strobe.
    logic [7:0] t_r1, t_r2, t_pd;
    logic       t_pend, t_psel, t_cs1, t_cs2, t_drv;
    logic [1:0] t_rc;

    assign t_cs1 = !reg1_cs_b[g];
    assign t_cs2 = !reg2_cs_b[g];
    assign t_drv = (t_rc == 2'd2) && !read_strobe_b[g] && (t_cs1 || t_cs2);
    assign data_in[g] = data_oe[g] ? data_out[g] :
                        t_drv ? (t_cs2 ? t_r2 : t_r1) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        t_r1   <= 8'h00;
        t_r2   <= 8'h00;
        t_pd   <= 8'h00;
        t_pend <= 1'b0;
        t_psel <= 1'b0;
        t_rc   <= 2'd0;
      end else begin
        if (!write_strobe_b[g] && (t_cs1 || t_cs2)) begin
          t_pend <= 1'b1;
          t_pd   <= data_in[g];
          t_psel <= t_cs2;
        end else if (t_pend) begin
          t_pend <= 1'b0;
          if (t_psel) t_r2 <= t_pd;
          else        t_r1 <= t_pd;
        end
        if (!read_strobe_b[g] && (t_cs1 || t_cs2))
          t_rc <= (t_rc == 2'd2) ? 2'd2 : t_rc + 2'd1;
        else
          t_rc <= 2'd0;
      end
    end
  end

  function automatic int p_s(input int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int p_t(input int d); return (d == 0) ? 4 : 3; endfunction
  function automatic int p_h(input int d); return (d == 0) ? 2 : 1; endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
               nm, act, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("mon_both_cs", !reg1_cs_b[d] && !reg2_cs_b[d], 0);
      chk("mon_both_stb", !write_strobe_b[d] && !read_strobe_b[d], 0);
      chk("mon_oe_on_read", data_oe[d] && !read_strobe_b[d], 0);
    end
  endtask

  task automatic chk_idle(input int d, input string nm);
    logic [23:0] want;
    want = {8'h9E, 16'h0000};
    chk(nm, {cmd_ready[d], rsp_valid[d], rsp_write[d], reg1_cs_b[d],
             reg2_cs_b[d], write_strobe_b[d], read_strobe_b[d],
             data_oe[d], rsp_rdata[d], data_out[d]}, want);
  endtask

  task automatic pop_chk(input int d);
    exp_t e;
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_write", rsp_write[d], e.w);
      chk("rsp_rdata", rsp_rdata[d], e.rd);
    end
  endtask

  task automatic run_cmd(input int d, input logic w, input logic r,
                         input logic [7:0] wd, input logic [7:0] erd);
    int n, t0, ws_n, rs_n, sel_n, oth_n, oe_n, dbad;
    cmd_valid[d] = 1'b1;
    cmd_write[d] = w;
    cmd_reg[d]   = r;
    cmd_wdata[d] = wd;
    rsp_ready[d] = 1'b1;
    n = 0;
    while (!cmd_ready[d] && n < 50) begin tick(); n++; end
    chk("accept_wait", n < 50, 1);
    t0 = cyc;
    tick();
    cmd_valid[d] = 1'b0;
    cmd_wdata[d] = ~wd;
    cmd_write[d] = ~w;
    cmd_reg[d]   = ~r;
    sb.push_back('{w: w, rd: (w ? 8'h00 : erd)});
    ws_n = 0; rs_n = 0; sel_n = 0; oth_n = 0; oe_n = 0; dbad = 0;
    n = 0;
    while (!rsp_valid[d] && n < 100) begin
      if (!write_strobe_b[d]) ws_n++;
      if (!read_strobe_b[d]) rs_n++;
      if (!(r ? reg2_cs_b[d] : reg1_cs_b[d])) sel_n++;
      if (!(r ? reg1_cs_b[d] : reg2_cs_b[d])) oth_n++;
      if (data_oe[d]) begin
        oe_n++;
        if (data_out[d] !== wd) dbad++;
      end
      tick();
      n++;
    end
    chk("rsp_wait", n < 100, 1);
    chk("latency", cyc - t0 - 1, 1 + p_s(d) + p_t(d) + p_h(d));
    chk("wstb_cycles", ws_n, w ? p_t(d) : 0);
    chk("rstb_cycles", rs_n, w ? 0 : p_t(d));
    chk("cs_sel_cycles", sel_n, p_s(d) + p_t(d) + p_h(d));
    chk("cs_other_cycles", oth_n, 0);
    chk("oe_cycles", oe_n, w ? p_s(d) + p_t(d) + p_h(d) : 0);
    chk("wdata_stable", dbad, 0);
    pop_chk(d);
    tick();
    chk("rsp_drop", rsp_valid[d], 0);
    chk("ready_back", cmd_ready[d], 1);
  endtask

  initial begin
    int n;
    logic [7:0] m[2];
    logic w, r;
    logic [7:0] wd;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_write[d] = 1'b0;
      cmd_reg[d]   = 1'b0;
      cmd_wdata[d] = 8'h00;
      rsp_ready[d] = 1'b0;
    end

    vt[0] = '{1'b0, 0, 1'b1, REG_SEL_1, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 0, 1'b0, REG_SEL_1, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 0, 1'b1, REG_SEL_2, 8'h3C, 8'h00};
    vt[3] = '{1'b0, 0, 1'b0, REG_SEL_1, 8'h00, 8'h00};
    vt[4] = '{1'b0, 0, 1'b0, REG_SEL_2, 8'h00, 8'h3C};
    vt[5] = '{1'b0, 1, 1'b1, REG_SEL_1, 8'h5A, 8'h00};
    vt[6] = '{1'b0, 1, 1'b0, REG_SEL_1, 8'h00, 8'h5A};
    vt[7] = '{1'b0, 1, 1'b1, REG_SEL_2, 8'h81, 8'h00};
    vt[8] = '{1'b0, 1, 1'b0, REG_SEL_2, 8'h00, 8'h81};
    vt[9] = '{1'b0, 1, 1'b0, REG_SEL_1, 8'h00, 8'h5A};

    tick();
    tick();
    chk_idle(0, "reset_values_d0");
    chk_idle(1, "reset_values_d1");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vt[i].pre_rst) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
      end
      run_cmd(vt[i].d, vt[i].w, vt[i].r, vt[i].wd, vt[i].rd);
    end

    // Stalled response: next command is offered but must wait.
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_reg[0]   = REG_SEL_2;
    rsp_ready[0] = 1'b0;
    n = 0;
    while (!cmd_ready[0] && n < 50) begin tick(); n++; end
    tick();
    sb.push_back('{w: 1'b0, rd: 8'h3C});
    cmd_write[0] = 1'b1;
    cmd_reg[0]   = REG_SEL_1;
    cmd_wdata[0] = 8'h77;
    n = 0;
    while (!rsp_valid[0] && n < 100) begin tick(); n++; end
    chk("stall_rsp_wait", n < 100, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_cmd_ready", cmd_ready[0], 0);
      chk("stall_rsp_valid", rsp_valid[0], 1);
      chk("stall_rdata", rsp_rdata[0], 8'h3C);
    end
    pop_chk(0);
    rsp_ready[0] = 1'b1;
    tick();
    chk("stall_release_valid", rsp_valid[0], 0);
    chk("stall_release_ready", cmd_ready[0], 1);
    tick();
    chk("next_accepted", cmd_ready[0], 0);
    sb.push_back('{w: 1'b1, rd: 8'h00});
    cmd_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 100) begin tick(); n++; end
    chk("next_rsp_wait", n < 100, 1);
    pop_chk(0);
    tick();
    run_cmd(0, 1'b0, REG_SEL_1, 8'h00, 8'h77);

    // Reset during the second strobe cycle of a write.
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b1;
    cmd_reg[0]   = REG_SEL_1;
    cmd_wdata[0] = 8'hFF;
    n = 0;
    while (!cmd_ready[0] && n < 50) begin tick(); n++; end
    tick();
    cmd_valid[0] = 1'b0;
    n = 0;
    while (write_strobe_b[0] && n < 20) begin tick(); n++; end
    chk("abort_strobe_seen", n < 20, 1);
    tick();
    chk("abort_in_strobe", write_strobe_b[0], 0);
    rst = 1'b1;
    #1;
    chk_idle(0, "abort_async_reset");
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid[0]) n++;
    end
    chk("abort_no_rsp", n, 0);
    run_cmd(0, 1'b0, REG_SEL_1, 8'h00, 8'h00);

    m[0] = 8'h00;
    m[1] = 8'h00;
    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wd = 8'($urandom_range(0, 255));
      run_cmd(0, w, r, wd, m[r]);
      if (w) m[r] = wd;
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
